// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the three-master memory arbiter.
// Owner codes double as the value driven on the owner port.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_OAM  = 2'd2,
        OWN_DMC  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int MAXSTARVE_DEF = 4;
    localparam int TIMEOUT_DEF   = 64;
    localparam int TW_DEF        = 7;

    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

    // reqs is {dmc, oam, cpu}; a starved CPU overrides the fixed priority.
    function automatic owner_t mem_arb_pick(input logic [2:0] reqs, input logic starve_hit);
        owner_t win;
        win = OWN_NONE;
        if (starve_hit) begin
            win = OWN_CPU;
        end else if (reqs[2]) begin
            win = OWN_DMC;
        end else if (reqs[1]) begin
            win = OWN_OAM;
        end else if (reqs[0]) begin
            win = OWN_CPU;
        end
        return win;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One req/ack bus: used for each upstream master and for the downstream memory port.
interface mem_arbiter_if;

    logic        req;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wr;
    logic        ack;
    logic [7:0]  rdata;

    modport master (
        output req, addr, wdata, wr,
        input  ack, rdata
    );

    modport slave (
        input  req, addr, wdata, wr,
        output ack, rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing the memory bus between CPU, OAM DMA and DMC fetch,
// one transaction at a time, with CPU anti-starvation and a downstream timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAXSTARVE = MAXSTARVE_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int TW        = TW_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    mem_arbiter_if.slave         cpu,
    mem_arbiter_if.slave         oam,
    mem_arbiter_if.slave         dmc,
    mem_arbiter_if.master        mem,
    output logic [1:0]           owner,
    output logic                 timeout_err
);

    localparam int SW = $clog2(MAXSTARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAXSTARVE);
    localparam logic [TW-1:0] TLAST      = TW'(TIMEOUT - 1);

    state_t        state;
    owner_t        own_q;
    logic [SW-1:0] starve;
    logic [TW-1:0] tcnt;

    logic          mem_req_q;
    logic [15:0]   mem_addr_q;
    logic [7:0]    mem_wdata_q;
    logic          mem_wr_q;
    logic [2:0]    ack_q;
    logic [7:0]    cpu_rdata_q;
    logic [7:0]    oam_rdata_q;
    logic [7:0]    dmc_rdata_q;
    logic          terr_q;

    logic [2:0]    reqs;
    logic          starve_hit;
    owner_t        pick;
    logic [15:0]   sel_addr;
    logic [7:0]    sel_wdata;
    logic          sel_wr;
    logic          done;
    logic [7:0]    resp;

    assign reqs       = {dmc.req, oam.req, cpu.req};
    assign starve_hit = (starve == STARVE_MAX) && cpu.req;
    assign pick       = mem_arb_pick(reqs, starve_hit);

    // A real mem_ack in the last timeout cycle still wins over the abort.
    assign done = mem.ack || (tcnt == TLAST);
    assign resp = mem.ack ? mem.rdata : RDATA_TIMEOUT;

    always_comb begin
        sel_addr  = cpu.addr;
        sel_wdata = cpu.wdata;
        sel_wr    = cpu.wr;
        case (pick)
            OWN_OAM: begin
                sel_addr  = oam.addr;
                sel_wdata = oam.wdata;
                sel_wr    = oam.wr;
            end
            OWN_DMC: begin
                sel_addr  = dmc.addr;
                sel_wdata = 8'h00;
                sel_wr    = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            own_q       <= OWN_NONE;
            starve      <= '0;
            tcnt        <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
            mem_wr_q    <= 1'b0;
            ack_q       <= 3'b000;
            cpu_rdata_q <= 8'h00;
            oam_rdata_q <= 8'h00;
            dmc_rdata_q <= 8'h00;
            terr_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!cpu.req) begin
                        starve <= '0;
                    end
                    if (pick != OWN_NONE) begin
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_wdata;
                        mem_wr_q    <= sel_wr;
                        mem_req_q   <= 1'b1;
                        own_q       <= pick;
                        tcnt        <= '0;
                        state       <= ST_BUSY;
                        // DMA grants only count against the CPU while it is waiting.
                        if (pick == OWN_CPU) begin
                            starve <= '0;
                        end else if (cpu.req && (starve != STARVE_MAX)) begin
                            starve <= starve + 1'b1;
                        end
                    end
                end

                ST_BUSY: begin
                    tcnt <= tcnt + 1'b1;
                    if (done) begin
                        mem_req_q <= 1'b0;
                        terr_q    <= !mem.ack;
                        state     <= ST_ACK;
                        case (own_q)
                            OWN_CPU: begin
                                ack_q[0] <= 1'b1;
                                if (!mem_wr_q) cpu_rdata_q <= resp;
                            end
                            OWN_OAM: begin
                                ack_q[1] <= 1'b1;
                                if (!mem_wr_q) oam_rdata_q <= resp;
                            end
                            OWN_DMC: begin
                                ack_q[2] <= 1'b1;
                                dmc_rdata_q <= resp;
                            end
                            default: ;
                        endcase
                    end
                end

                ST_ACK: begin
                    ack_q  <= 3'b000;
                    terr_q <= 1'b0;
                    own_q  <= OWN_NONE;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.req     = mem_req_q;
    assign mem.addr    = mem_addr_q;
    assign mem.wdata   = mem_wdata_q;
    assign mem.wr      = mem_wr_q;

    assign cpu.ack     = ack_q[0];
    assign oam.ack     = ack_q[1];
    assign dmc.ack     = ack_q[2];
    assign cpu.rdata   = cpu_rdata_q;
    assign oam.rdata   = oam_rdata_q;
    assign dmc.rdata   = dmc_rdata_q;

    assign owner       = own_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expectations are queued in grant order when
// requests are driven and retired whenever any master's ack pulses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [1:0] owner;
    logic       timeout_err;

    always #5 clk = ~clk;

    mem_arbiter_if cpu_bus ();
    mem_arbiter_if oam_bus ();
    mem_arbiter_if dmc_bus ();
    mem_arbiter_if mem_bus ();

    mem_arbiter #(
        .MAXSTARVE(4),
        .TIMEOUT(64),
        .TW(7)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cpu(cpu_bus),
        .oam(oam_bus),
        .dmc(dmc_bus),
        .mem(mem_bus),
        .owner(owner),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [1:0]  own;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        wr;
        logic [7:0]  rdata;
        logic        terr;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] owner_log[$];
    logic [7:0] model_rdata[1:3];
    int         left[1:3];
    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         mem_wait = 0;
    bit         mem_noack = 1'b0;
    int         mcnt = 0;
    int         last_ack_cycle = 0;
    int         last_req_len = 0;
    int         req_len = 0;
    logic [1:0] prev_owner = 2'd0;
    logic       prev_req = 1'b0;
    logic [15:0] cap_addr = 16'h0;
    logic [7:0] cap_wdata = 8'h0;
    logic       cap_wr = 1'b0;
    logic [1:0] cap_owner = 2'd0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_value(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hDA;
    endfunction

    function automatic logic [7:0] rd_of(input logic [1:0] o);
        case (o)
            2'd1:    return cpu_bus.rdata;
            2'd2:    return oam_bus.rdata;
            2'd3:    return dmc_bus.rdata;
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_expect(input logic [1:0] o, input logic [15:0] a, input logic [7:0] d,
                               input logic w, input logic terr);
        exp_t e;
        e.own   = o;
        e.addr  = a;
        e.wdata = d;
        e.wr    = w;
        e.terr  = terr;
        e.rdata = terr ? 8'hFF : mem_value(a);
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input int m, input logic [15:0] a, input logic [7:0] d,
                                  input logic w, input int n);
        left[m] = n;
        case (m)
            1: begin cpu_bus.addr = a; cpu_bus.wdata = d; cpu_bus.wr = w; cpu_bus.req = 1'b1; end
            2: begin oam_bus.addr = a; oam_bus.wdata = d; oam_bus.wr = w; oam_bus.req = 1'b1; end
            default: begin dmc_bus.addr = a; dmc_bus.req = 1'b1; end
        endcase
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && left[1] == 0 && left[2] == 0 && left[3] == 0) return;
        end
        check_output("wait_done_budget", 0, 1);
        cpu_bus.req = 1'b0;
        oam_bus.req = 1'b0;
        dmc_bus.req = 1'b0;
        left[1] = 0;
        left[2] = 0;
        left[3] = 0;
        exp_q.delete();
    endtask

    task automatic handle_ack();
        exp_t       e;
        logic [1:0] got_own;
        logic [7:0] exp_rd;
        int         n_acks;
        n_acks  = int'(cpu_bus.ack) + int'(oam_bus.ack) + int'(dmc_bus.ack);
        got_own = dmc_bus.ack ? 2'd3 : (oam_bus.ack ? 2'd2 : 2'd1);
        check_output("single_ack", n_acks, 1);
        if (exp_q.size() == 0) begin
            check_output("unexpected_ack", got_own, 0);
        end else begin
            e = exp_q.pop_front();
            check_output("ack_master", got_own, e.own);
            check_output("owner_in_ack", owner, e.own);
            check_output("grant_owner", cap_owner, e.own);
            check_output("mem_addr", cap_addr, e.addr);
            check_output("mem_wr", cap_wr, e.wr);
            if (e.wr) check_output("mem_wdata", cap_wdata, e.wdata);
            if (e.wr) begin
                exp_rd = model_rdata[e.own];
            end else begin
                exp_rd = e.rdata;
                model_rdata[e.own] = e.rdata;
            end
            check_output("rdata", rd_of(e.own), exp_rd);
            check_output("timeout_err", timeout_err, e.terr);
            check_output("mem_req_in_ack", mem_bus.req, 0);
        end
        last_ack_cycle = cycle;
    endtask

    // Memory model: acks after mem_wait BUSY cycles unless mem_noack is set.
    initial begin
        mem_bus.ack   = 1'b0;
        mem_bus.rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mem_bus.req === 1'b1) begin
                if (!mem_noack && mcnt == mem_wait) begin
                    mem_bus.ack   = 1'b1;
                    mem_bus.rdata = mem_value(mem_bus.addr);
                end else begin
                    mem_bus.ack   = 1'b0;
                    mem_bus.rdata = 8'h00;
                end
                mcnt++;
            end else begin
                mem_bus.ack = 1'b0;
                mcnt = 0;
            end
        end
    end

    // Masters drop req after their last requested ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cpu_bus.ack && left[1] > 0) begin left[1]--; if (left[1] == 0) cpu_bus.req = 1'b0; end
            if (oam_bus.ack && left[2] > 0) begin left[2]--; if (left[2] == 0) oam_bus.req = 1'b0; end
            if (dmc_bus.ack && left[3] > 0) begin left[3]--; if (left[3] == 0) dmc_bus.req = 1'b0; end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (owner != prev_owner) begin
                owner_log.push_back(owner);
                prev_owner = owner;
            end
            if (mem_bus.req && !prev_req) begin
                cap_addr  = mem_bus.addr;
                cap_wdata = mem_bus.wdata;
                cap_wr    = mem_bus.wr;
                cap_owner = owner;
                req_len   = 0;
            end else if (mem_bus.req && prev_req) begin
                check_output("mem_stable", {mem_bus.addr, mem_bus.wdata, mem_bus.wr},
                             {cap_addr, cap_wdata, cap_wr});
            end
            if (mem_bus.req) req_len++;
            else if (prev_req) last_req_len = req_len;
            prev_req = mem_bus.req;
            if (cpu_bus.ack || oam_bus.ack || dmc_bus.ack) handle_ack();
            else if (timeout_err) check_output("stray_timeout_err", 1, 0);
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] exp_seq [5];
        logic [1:0] got;
        int         t0;
        exp_seq = '{2'd3, 2'd0, 2'd2, 2'd0, 2'd1};
        for (int i = 1; i <= 3; i++) begin
            left[i] = 0;
            model_rdata[i] = 8'h00;
        end
        cpu_bus.req = 1'b0; cpu_bus.addr = 16'h0; cpu_bus.wdata = 8'h0; cpu_bus.wr = 1'b0;
        oam_bus.req = 1'b0; oam_bus.addr = 16'h0; oam_bus.wdata = 8'h0; oam_bus.wr = 1'b0;
        dmc_bus.req = 1'b0; dmc_bus.addr = 16'h0; dmc_bus.wdata = 8'h0; dmc_bus.wr = 1'b0;

        repeat (3) @(negedge clk);
        check_output("rst_mem_req", mem_bus.req, 0);
        check_output("rst_owner", owner, 0);
        check_output("rst_acks", {cpu_bus.ack, oam_bus.ack, dmc_bus.ack}, 0);
        check_output("rst_timeout_err", timeout_err, 0);
        check_output("rst_rdata", {cpu_bus.rdata, oam_bus.rdata, dmc_bus.rdata}, 0);
        check_output("rst_mem_bus", {mem_bus.addr, mem_bus.wdata, mem_bus.wr}, 0);
        rstn = 1'b1;
        @(negedge clk);

        $display("[TB] CPU read, zero-wait memory");
        push_expect(2'd1, 16'h8000, 8'h00, 1'b0, 1'b0);
        t0 = cycle;
        apply_stimulus(1, 16'h8000, 8'h00, 1'b0, 1);
        wait_done(20);
        check_output("cpu_latency", last_ack_cycle - t0, 2);
        check_output("busy_len_zero_wait", last_req_len, 1);
        check_output("cpu_rdata_5a", cpu_bus.rdata, 8'h5A);

        $display("[TB] simultaneous requests");
        @(negedge clk);
        owner_log.delete();
        push_expect(2'd3, 16'hC000, 8'h00, 1'b0, 1'b0);
        push_expect(2'd2, 16'h2100, 8'h00, 1'b0, 1'b0);
        push_expect(2'd1, 16'h8001, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1, 16'h8001, 8'h00, 1'b0, 1);
        apply_stimulus(2, 16'h2100, 8'h00, 1'b0, 1);
        apply_stimulus(3, 16'hC000, 8'h00, 1'b0, 1);
        wait_done(60);
        for (int i = 0; i < 5; i++) begin
            got = (i < owner_log.size()) ? owner_log[i] : 2'bxx;
            check_output("owner_sequence", got, exp_seq[i]);
        end

        $display("[TB] OAM write");
        @(negedge clk);
        push_expect(2'd2, 16'h2004, 8'hA7, 1'b1, 1'b0);
        apply_stimulus(2, 16'h2004, 8'hA7, 1'b1, 1);
        wait_done(20);

        $display("[TB] CPU starvation guard");
        @(negedge clk);
        for (int i = 0; i < 4; i++) push_expect(2'd2, 16'h2200, 8'h00, 1'b0, 1'b0);
        push_expect(2'd1, 16'h8002, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) push_expect(2'd2, 16'h2200, 8'h00, 1'b0, 1'b0);
        apply_stimulus(1, 16'h8002, 8'h00, 1'b0, 1);
        apply_stimulus(2, 16'h2200, 8'h00, 1'b0, 6);
        wait_done(200);

        $display("[TB] downstream timeout");
        @(negedge clk);
        mem_noack = 1'b1;
        push_expect(2'd1, 16'h8003, 8'h00, 1'b0, 1'b1);
        apply_stimulus(1, 16'h8003, 8'h00, 1'b0, 1);
        wait_done(200);
        check_output("busy_len_timeout", last_req_len, 64);
        mem_noack = 1'b0;

        $display("[TB] ack in the timeout cycle");
        @(negedge clk);
        mem_wait = 63;
        push_expect(2'd3, 16'h9000, 8'h00, 1'b0, 1'b0);
        apply_stimulus(3, 16'h9000, 8'h00, 1'b0, 1);
        wait_done(200);
        check_output("busy_len_late_ack", last_req_len, 64);
        mem_wait = 0;

        $display("[TB] reset during BUSY");
        @(negedge clk);
        mem_noack = 1'b1;
        apply_stimulus(1, 16'h8004, 8'h00, 1'b0, 1);
        repeat (5) @(negedge clk);
        check_output("busy_before_reset", mem_bus.req, 1);
        #2;
        rstn = 1'b0;
        for (int i = 1; i <= 3; i++) model_rdata[i] = 8'h00;
        #1;
        check_output("reset_mem_req", mem_bus.req, 0);
        check_output("reset_owner", owner, 0);
        check_output("reset_acks", {cpu_bus.ack, oam_bus.ack, dmc_bus.ack}, 0);
        check_output("reset_cpu_rdata", cpu_bus.rdata, 8'h00);
        cpu_bus.req = 1'b0;
        left[1] = 0;
        mem_noack = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        push_expect(2'd1, 16'h8005, 8'h00, 1'b0, 1'b0);
        t0 = cycle;
        apply_stimulus(1, 16'h8005, 8'h00, 1'b0, 1);
        wait_done(20);
        check_output("post_reset_latency", last_ack_cycle - t0, 2);

        repeat (5) @(negedge clk);
        check_output("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Single-port memory arbiter that shares the CPU bus between three masters: the CPU, the OAM sprite DMA engine and the APU DMC sample fetcher. It sits between those masters and the memory/mapper decode, and sequences one transaction at a time over a req/ack handshake. Fixed priority (DMC > OAM > CPU), a CPU anti-starvation guard and a downstream timeout.

Parameters:
MAXSTARVE, 4, consecutive DMA grants allowed while cpu_req is pending before the CPU is forced to win.
TIMEOUT, 64, cycles in BUSY without mem_ack before the transaction is aborted.
TW, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
cpu_req  in  1  CPU request; addr/wdata/wr held stable while high
cpu_addr  in  16  CPU address
cpu_wdata  in  8  CPU write data
cpu_wr  in  1  1 = write
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  8  read data, valid when cpu_ack is high and held until the next ack
oam_req / oam_addr / oam_wdata / oam_wr  in  1/16/8/1  OAM DMA master, same rules as CPU
oam_ack / oam_rdata  out  1/8  as for CPU
dmc_req / dmc_addr  in  1/16  DMC fetch, read-only
dmc_ack / dmc_rdata  out  1/8  as for CPU
mem_req  out  1  downstream request
mem_addr / mem_wdata / mem_wr  out  16/8/1  registered copy of the granted master's signals
mem_ack  in  1  downstream completion
mem_rdata  in  8  downstream read data, valid with mem_ack
owner  out  2  current grant: 0 none, 1 CPU, 2 OAM, 3 DMC
timeout_err  out  1  one-cycle pulse on an aborted transaction

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; mem_req, all acks, timeout_err, owner = 0; all rdata = 8'h00; mem_addr/mem_wdata = 0; mem_wr = 0; starve and timeout counters = 0. A reset mid-transaction drops mem_req immediately, and no ack is issued.
- States: IDLE, BUSY, ACK.
- IDLE: pick the winner among the pending reqs. DMC is highest and CPU lowest. Exception: when starve == MAXSTARVE and cpu_req is high, the CPU wins. On the next edge the block latches the winner's addr/wdata/wr into mem_*, sets mem_req = 1, sets owner, clears the timeout counter and goes to BUSY. With no req it stays in IDLE.
- Starve counter: increments on each OAM/DMC grant while cpu_req is high. It resets to 0 on a CPU grant, and whenever cpu_req is low in IDLE. It saturates at MAXSTARVE.
- BUSY: mem_* are held stable. The timeout counter increments every cycle.
  - mem_ack high: next edge sets mem_req = 0, pulses the owner's ack = 1, loads the owner's rdata with mem_rdata (reads only; a write leaves rdata unchanged) and goes to ACK.
  - Counter reaches TIMEOUT-1 with no mem_ack: next edge sets mem_req = 0, pulses the owner's ack, loads rdata = 8'hFF on a read, pulses timeout_err = 1 and goes to ACK.
  - mem_ack arriving in the timeout cycle: mem_ack wins, real data is returned and there is no error.
- ACK: exactly one cycle. The ack is high, and the just-served master's req is masked from arbitration. Next edge: ack = 0, timeout_err = 0, owner = 0, state IDLE.
- Latency: a req seen in IDLE at edge N gives mem_req high after N. A mem_ack seen at edge M gives the ack high after M. Minimum req-to-ack is 2 edges with a zero-wait memory.
- Masters must drop req the edge after they sample ack. A req still high in the cycle after ACK is treated as a new request.
- A req that drops while un-granted is simply lost; no error.
- A grant is never pre-empted: a higher-priority req during BUSY waits for IDLE.
- Address and data are never modified. Widths are exact, with no sign or extension rules.

Decomposition:
- Owner codes OWN_NONE/CPU/OAM/DMC and the state encodings go in dat.vh as localparam/`define.
- The winner-select logic is small; no sub-module. Optionally a combinational mem_arb_pick(reqs, starve_hit, mask) -> owner.

Test Plan:
- CPU read 16'h8000, memory acks 1 cycle after mem_req with 8'h5A -> mem_addr = 16'h8000, mem_wr = 0; cpu_ack pulses once, 2 edges after cpu_req; cpu_rdata = 8'h5A.
- cpu_req, oam_req and dmc_req rise in the same cycle -> grants in order DMC, OAM, CPU; each ack pulses once; owner goes 3, 0, 2, 0, 1.
- OAM write 16'h2004 / 8'hA7 -> mem_wr = 1, mem_wdata = 8'hA7; oam_ack pulses; oam_rdata unchanged.
- oam_req held continuously with cpu_req pending -> after 4 OAM grants the CPU is granted; the counter then resets and OAM resumes.
- mem_ack never asserted -> after 64 BUSY cycles mem_req drops; cpu_ack and timeout_err pulse together; cpu_rdata = 8'hFF.
- rstn pulled low mid-BUSY -> mem_req and owner go to 0 immediately, no ack; after release a new req is served normally.
